// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz timing constants, receiver FSM encoding and pixel helpers.
// Used by the VGA receiver (optional VGA_RX_MEASURE_EN build) and the transmitter.
package vga_timing_pkg;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_H_ADJ     = 0;

  localparam int unsigned H_TOTAL     = VGA_H_SYNC + VGA_H_BACK + VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int unsigned V_TOTAL     = VGA_V_SYNC + VGA_V_BACK + VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int unsigned H_ACT_START = VGA_H_SYNC + VGA_H_BACK + VGA_H_ADJ;
  localparam int unsigned V_ACT_START = VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SEARCH   = 2'd1,
    LOCKED   = 2'd2
  } rx_state_e;

  // Gray = (r + 2g + b) scaled by 4; all channels at 0xF gives 240
  function automatic logic [7:0] rgb_to_gray(input logic [3:0] r, input logic [3:0] g,
                                             input logic [3:0] b);
    logic [5:0] sum;
    sum = 6'(r) + 6'({g, 1'b0}) + 6'(b);
    return {sum, 2'b00};
  endfunction

  // Increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc16(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge_det.sv
// Registers the raw sync pins once and flags falling edges of hsync/vsync.
module vga_sync_edge_det (
  input  logic clk_25mhz,
  input  logic rst_n,
  input  logic hsync_in,
  input  logic vsync_in,
  output logic hs_fall_c,
  output logic vs_fall_c
);

  logic hs_s1_q, vs_s1_q, hs_prev_q, vs_prev_q;

  // Input stage plus one-cycle history; reset low so a low pin at release is not an edge
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      hs_s1_q   <= hsync_in;
      vs_s1_q   <= vsync_in;
      hs_prev_q <= hs_s1_q;
      vs_prev_q <= vs_s1_q;
    end
  end

  assign hs_fall_c = hs_prev_q & ~hs_s1_q;
  assign vs_fall_c = vs_prev_q & ~vs_s1_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receive side: coordinate recovery, sync lock FSM, gray conversion, pixel strobes.
// Define VGA_RX_MEASURE_EN to add meas_h_total / meas_v_total outputs.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter int unsigned H_ADJ     = VGA_H_ADJ
) (
  input  logic              clk_25mhz,
  input  logic              rst_n,
  input  logic              vga_hsync_in,
  input  logic              vga_vsync_in,
  input  logic [3:0]        vga_r_in,
  input  logic [3:0]        vga_g_in,
  input  logic [3:0]        vga_b_in,
  output logic              pix_valid,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic [7:0]        pix_gray,
  output logic              frame_start,
  output logic              locked,
  output logic              sync_err
`ifdef VGA_RX_MEASURE_EN
  ,
  output logic [CNT_W-1:0]  meas_h_total,
  output logic [CNT_W-1:0]  meas_v_total
`endif
);

  localparam int unsigned LINE_CLKS    = H_SYNC + H_BACK + H_DISPLAY + H_FRONT;
  localparam int unsigned FRAME_LINES  = V_SYNC + V_BACK + V_DISPLAY + V_FRONT;
  localparam int unsigned COL_START    = H_SYNC + H_BACK + H_ADJ;
  localparam int unsigned COL_END      = COL_START + H_DISPLAY - 1;
  localparam int unsigned ROW_START    = V_SYNC + V_BACK;
  localparam int unsigned ROW_END      = ROW_START + V_DISPLAY - 1;
  localparam int unsigned TIMEOUT_CLKS = 2 * LINE_CLKS;

  logic hs_fall_c, vs_fall_c;

  vga_sync_edge_det u_edge_det (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .hsync_in  (vga_hsync_in),
    .vsync_in  (vga_vsync_in),
    .hs_fall_c (hs_fall_c),
    .vs_fall_c (vs_fall_c)
  );

  logic [3:0] r_q, g_q, b_q;

  // Colour S1 register, aligned with the sync S1 register inside the edge detector
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 4'd0;
      g_q <= 4'd0;
      b_q <= 4'd0;
    end else begin
      r_q <= vga_r_in;
      g_q <= vga_g_in;
      b_q <= vga_b_in;
    end
  end

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [7:0]       pix_gray_q, pix_gray_d;
  logic             v_arm_q, v_arm_d, h_bad_q, h_bad_d;
  logic             pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic             locked_q, locked_d, sync_err_q, sync_err_d;
  logic             h_err_c, in_window_c, timeout_c;
  logic [CNT_W-1:0] lines_c;

  // A line period is h_cnt of the last sample before the fall, plus one
  assign h_err_c = hs_fall_c && (h_cnt_q != CNT_W'(LINE_CLKS - 1));
  // Lines in the frame that ends now; a coincident hsync fall belongs to it
  assign lines_c = hs_fall_c ? sat_inc16(line_cnt_q) : line_cnt_q;

  // Counters, lock FSM and output-stage next values for the pixel currently in S1
  always_comb begin
    h_cnt_d       = hs_fall_c ? '0 : sat_inc16(h_cnt_q);
    v_cnt_d       = v_cnt_q;
    v_arm_d       = v_arm_q;
    line_cnt_d    = vs_fall_c ? '0 : lines_c;
    h_bad_d       = vs_fall_c ? 1'b0 : (h_bad_q | h_err_c);
    state_d       = state_q;
    sync_err_d    = 1'b0;
    in_window_c   = 1'b0;
    timeout_c     = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_gray_d    = pix_gray_q;

    // hsync is handled before vsync so a coincident vsync arms the following line
    if (hs_fall_c) begin
      v_cnt_d = v_arm_q ? '0 : sat_inc16(v_cnt_q);
      v_arm_d = 1'b0;
    end
    if (vs_fall_c) v_arm_d = 1'b1;

    unique case (state_q)
      UNLOCKED: if (vs_fall_c) state_d = SEARCH;
      SEARCH: begin
        if (vs_fall_c && !h_bad_q && !h_err_c && (lines_c == CNT_W'(FRAME_LINES)))
          state_d = LOCKED;
      end
      LOCKED: begin
        if (h_err_c || (vs_fall_c && (lines_c != CNT_W'(FRAME_LINES)))) begin
          sync_err_d = 1'b1;
          state_d    = SEARCH;
        end
      end
      default: state_d = UNLOCKED;
    endcase

    // Lost hsync drops lock silently
    timeout_c = (h_cnt_d >= CNT_W'(TIMEOUT_CLKS));
    if (timeout_c) begin
      state_d    = UNLOCKED;
      sync_err_d = 1'b0;
    end

    locked_d    = (state_d == LOCKED);
    in_window_c = (h_cnt_d >= CNT_W'(COL_START)) && (h_cnt_d <= CNT_W'(COL_END)) &&
                  (v_cnt_d >= CNT_W'(ROW_START)) && (v_cnt_d <= CNT_W'(ROW_END));
    pix_valid_d = in_window_c && locked_d;
    if (pix_valid_d) begin
      pix_x_d    = CNT_W'(h_cnt_d - CNT_W'(COL_START));
      pix_y_d    = CNT_W'(v_cnt_d - CNT_W'(ROW_START));
      pix_gray_d = rgb_to_gray(r_q, g_q, b_q);
    end
    frame_start_d = pix_valid_d && (pix_x_d == '0) && (pix_y_d == '0);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= UNLOCKED;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_cnt_q    <= '0;
      v_arm_q       <= 1'b0;
      h_bad_q       <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_gray_q    <= 8'd0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_cnt_q    <= line_cnt_d;
      v_arm_q       <= v_arm_d;
      h_bad_q       <= h_bad_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_gray_q    <= pix_gray_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_gray    = pix_gray_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

`ifdef VGA_RX_MEASURE_EN
  logic [CNT_W-1:0] last_hp_q, last_hp_d, meas_h_q, meas_h_d, meas_v_q, meas_v_d;

  // Track the latest line period; latch both totals on every vsync fall
  always_comb begin
    last_hp_d = last_hp_q;
    meas_h_d  = meas_h_q;
    meas_v_d  = meas_v_q;
    if (hs_fall_c) last_hp_d = sat_inc16(h_cnt_q);
    if (vs_fall_c) begin
      meas_h_d = last_hp_d;
      meas_v_d = lines_c;
    end
  end

  // Measurement registers
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      last_hp_q <= '0;
      meas_h_q  <= '0;
      meas_v_q  <= '0;
    end else begin
      last_hp_q <= last_hp_d;
      meas_h_q  <= meas_h_d;
      meas_v_q  <= meas_v_d;
    end
  end

  assign meas_h_total = meas_h_q;
  assign meas_v_total = meas_v_q;
`else
  // Measurement registers are not built in this configuration
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced timing (25 clk lines, 11 line frames).
// Covers VGA_RX_MEASURE_EN when the macro is defined.
module tb_vga_sync_receiver;

  localparam int HD = 16, HF = 2, HS = 4, HB = 3;
  localparam int VD = 6, VF = 2, VS = 1, VB = 2;
  localparam int HT = 25;   // HS+HB+HD+HF
  localparam int VT = 11;   // VS+VB+VD+VF
  localparam int CS = 7;    // first active column count (HS+HB)
  localparam int RS = 3;    // first active row count (VS+VB)
  localparam int HALF = 20;
  localparam int NV = 8;

  logic        clk_25mhz = 1'b0;
  logic        rst_n;
  logic        vga_hsync_in, vga_vsync_in;
  logic [3:0]  vga_r_in, vga_g_in, vga_b_in;
  logic        pix_valid, frame_start, locked, sync_err;
  logic [15:0] pix_x, pix_y;
  logic [7:0]  pix_gray;
`ifdef VGA_RX_MEASURE_EN
  logic [15:0] meas_h_total, meas_v_total;
`endif

  always #HALF clk_25mhz = ~clk_25mhz;

  vga_sync_receiver #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .H_ADJ(0)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .rst_n        (rst_n),
    .vga_hsync_in (vga_hsync_in),
    .vga_vsync_in (vga_vsync_in),
    .vga_r_in     (vga_r_in),
    .vga_g_in     (vga_g_in),
    .vga_b_in     (vga_b_in),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_gray     (pix_gray),
    .frame_start  (frame_start),
    .locked       (locked),
    .sync_err     (sync_err)
`ifdef VGA_RX_MEASURE_EN
    ,
    .meas_h_total (meas_h_total),
    .meas_v_total (meas_v_total)
`endif
  );

  typedef struct {
    int         x;
    int         y;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [7:0] gray;
  } pix_vec_t;

  pix_vec_t   vecs [NV];
  int         n_checks = 0;
  int         n_err = 0;
  int         valid_cnt, fs_cnt, err_cnt;
  logic [15:0] fs_x, fs_y;
  logic       fs_pv, err_locked, hs_off;
  time        tx_t00, fs_time;
  logic [7:0] cap [8][16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] colour_at(input int x, input int y);
    logic [11:0] c;
    c = 12'd0;
    for (int i = 0; i < NV; i++)
      if (vecs[i].x == x && vecs[i].y == y) c = {vecs[i].r, vecs[i].g, vecs[i].b};
    return c;
  endfunction

  // Drive ncols clocks of transmitter line ln; row/col derive from the receiver's view
  task automatic send_line(input int ln, input int ncols);
    int row, col;
    for (int c = 0; c < ncols; c++) begin
      @(negedge clk_25mhz);
      vga_hsync_in = (hs_off || c >= HS) ? 1'b1 : 1'b0;
      vga_vsync_in = (ln < VS) ? 1'b0 : 1'b1;
      row = ln - RS - 1;
      col = c - CS;
      if (row >= 0 && row < VD && col >= 0 && col < HD) begin
        {vga_r_in, vga_g_in, vga_b_in} = colour_at(col, row);
        if (row == 0 && col == 0) tx_t00 = $time;
      end else begin
        {vga_r_in, vga_g_in, vga_b_in} = 12'd0;
      end
    end
  endtask

  task automatic send_frame(input int stretch_ln, input int len);
    for (int ln = 0; ln < VT; ln++) send_line(ln, (ln == stretch_ln) ? len + 1 : len);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_25mhz);
      vga_hsync_in = 1'b1;
      vga_vsync_in = 1'b1;
      {vga_r_in, vga_g_in, vga_b_in} = 12'd0;
    end
  endtask

  task automatic clear_mon();
    @(posedge clk_25mhz);
    valid_cnt = 0;
    fs_cnt    = 0;
    err_cnt   = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) cap[y][x] = 8'hAA;
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk_25mhz) begin
    if (pix_valid) begin
      valid_cnt++;
      if (pix_x < 16'(HD) && pix_y < 16'(VD)) cap[pix_y[2:0]][pix_x[3:0]] = pix_gray;
    end
    if (frame_start) begin
      fs_cnt++;
      fs_time = $time;
      fs_x    = pix_x;
      fs_y    = pix_y;
      fs_pv   = pix_valid;
    end
    if (sync_err) begin
      err_cnt++;
      err_locked = locked;
    end
  end

  initial begin
    vecs[0] = '{x: 0,  y: 0, r: 4'hF, g: 4'hF, b: 4'hF, gray: 8'd240};
    vecs[1] = '{x: 10, y: 5, r: 4'hF, g: 4'h0, b: 4'h0, gray: 8'd60};
    vecs[2] = '{x: 15, y: 5, r: 4'h0, g: 4'hF, b: 4'h0, gray: 8'd120};
    vecs[3] = '{x: 3,  y: 1, r: 4'h0, g: 4'h0, b: 4'hF, gray: 8'd60};
    vecs[4] = '{x: 7,  y: 3, r: 4'h1, g: 4'h2, b: 4'h3, gray: 8'd32};
    vecs[5] = '{x: 15, y: 0, r: 4'hF, g: 4'hF, b: 4'h0, gray: 8'd180};
    vecs[6] = '{x: 5,  y: 4, r: 4'h0, g: 4'h0, b: 4'h0, gray: 8'd0};
    vecs[7] = '{x: 11, y: 5, r: 4'h8, g: 4'h4, b: 4'h2, gray: 8'd72};

    hs_off = 1'b0;
    tx_t00 = 0;
    fs_time = 0;
    fs_x = 16'd0; fs_y = 16'd0; fs_pv = 1'b0; err_locked = 1'b0;
    vga_hsync_in = 1'b1;
    vga_vsync_in = 1'b1;
    {vga_r_in, vga_g_in, vga_b_in} = 12'd0;
    rst_n = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk_25mhz);
    check("rst_xy", {pix_x, pix_y}, 32'd0);
    check("rst_flags", 32'({pix_valid, frame_start, locked, sync_err, pix_gray}), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Frame 1 enters SEARCH, frame 2 starts locked
    send_frame(-1, HT);
    check("f1_locked", 32'(locked), 32'd0);
    clear_mon();
    send_frame(-1, HT);
    check("f2_locked", 32'(locked), 32'd1);
    check("f2_valid_cnt", 32'(valid_cnt), 32'd96);
    check("f2_fs_cnt", 32'(fs_cnt), 32'd1);
    check("f2_fs_xy", {fs_x, fs_y}, 32'd0);
    check("f2_fs_valid", 32'(fs_pv), 32'd1);
    check("f2_latency", 32'(fs_time - tx_t00), 32'(4 * HALF));
    check("f2_err_cnt", 32'(err_cnt), 32'd0);
    for (int i = 0; i < NV; i++)
      check($sformatf("gray_vec%0d", i), 32'(cap[vecs[i].y][vecs[i].x]), 32'(vecs[i].gray));

    // Frame 3: line 6 stretched by one clock while locked
    clear_mon();
    send_frame(6, HT);
    check("f3_err_cnt", 32'(err_cnt), 32'd1);
    check("f3_err_locked", 32'(err_locked), 32'd0);
    check("f3_valid_cnt", 32'(valid_cnt), 32'd48);
    check("f3_locked", 32'(locked), 32'd0);
    // Frame 4 is the clean measurement frame, frame 5 is locked again
    clear_mon();
    send_frame(-1, HT);
    check("f4_valid_cnt", 32'(valid_cnt), 32'd0);
    check("f4_locked", 32'(locked), 32'd0);
    check("f4_err_cnt", 32'(err_cnt), 32'd0);
    clear_mon();
    send_frame(-1, HT);
    check("f5_locked", 32'(locked), 32'd1);
    check("f5_valid_cnt", 32'(valid_cnt), 32'd96);

    // hsync stopped for three line times: silent unlock
    clear_mon();
    hs_off = 1'b1;
    for (int i = 0; i < 3; i++) send_line(VT - 1, HT);
    hs_off = 1'b0;
    check("to_locked", 32'(locked), 32'd0);
    check("to_err_cnt", 32'(err_cnt), 32'd0);
    clear_mon();
    send_frame(-1, HT);
    check("f7_locked", 32'(locked), 32'd0);
    check("f7_valid_cnt", 32'(valid_cnt), 32'd0);
    clear_mon();
    send_frame(-1, HT);
    check("f8_locked", 32'(locked), 32'd1);
    check("f8_valid_cnt", 32'(valid_cnt), 32'd96);

    // Reset asserted mid active line
    for (int ln = 0; ln < 6; ln++) send_line(ln, HT);
    send_line(6, 12);
    check("pre_rst_valid", 32'(pix_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_xy", {pix_x, pix_y}, 32'd0);
    check("mid_rst_flags", 32'({pix_valid, frame_start, locked, sync_err, pix_gray}), 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(5);
    clear_mon();
    send_frame(-1, HT);
    check("f10_locked", 32'(locked), 32'd0);
    clear_mon();
    send_frame(-1, HT);
    check("f11_locked", 32'(locked), 32'd1);
    check("f11_valid_cnt", 32'(valid_cnt), 32'd96);

`ifdef VGA_RX_MEASURE_EN
    // Lines eight clocks too long: measured, never locked
    send_frame(-1, HT + 8);
    send_line(0, HT + 8);
    check("meas_h_total", 32'(meas_h_total), 32'(HT + 8));
    check("meas_v_total", 32'(meas_v_total), 32'(VT));
    check("meas_locked", 32'(locked), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive side of the 640x480@60Hz VGA link: samples incoming hsync/vsync/4-bit RGB at the pixel clock.
- Recovers pixel coordinates, checks the sync timing and locks to it, converts RGB to 8-bit gray, and emits pixel write strobes.
- Sits between the external VGA/camera-bridge pins and the frame-buffer write port; used for loopback test and capture of the display stream.

Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_ADJ, 0, extra clocks (0..15) added to the active-start column to absorb source pipeline skew

Ports:
- clk_25mhz  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- vga_hsync_in  in  1  active-low hsync
- vga_vsync_in  in  1  active-low vsync
- vga_r_in / vga_g_in / vga_b_in  in  4 each  colour
- pix_valid  out  1  active pixel strobe (frame-buffer write enable)
- pix_x  out  16  column 0..H_DISPLAY-1
- pix_y  out  16  row 0..V_DISPLAY-1
- pix_gray  out  8  grayscale pixel
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
- locked  out  1  timing locked
- sync_err  out  1  one-cycle pulse on timing violation while locked

Behaviour:
- Reset: all outputs 0; FSM = UNLOCKED; counters 0.
- Input stage: all inputs registered once (stage S1). Edges are detected on S1 against its previous value.
- h_cnt:
  - cleared to 0 on the cycle an hsync falling edge is detected; otherwise increments.
  - saturates at 0xFFFF.
- v_cnt:
  - increments at each hsync fall.
  - a vsync fall sets v_arm; the next hsync fall then loads v_cnt = 0 and clears v_arm.
- Active window:
  - columns: h_cnt in [H_SYNC+H_BACK+H_ADJ, H_SYNC+H_BACK+H_ADJ+H_DISPLAY-1].
  - rows: v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISPLAY-1].
  - pix_x / pix_y = counter minus the window start.
- Output stage: registered.
  - pix_valid = in_window AND locked.
  - Latency: 2 clk_25mhz cycles from pin to pix_* output.
  - pix_x/pix_y/pix_gray hold their last value when pix_valid = 0.
- Gray: sum = r + 2g + b (6-bit, max 60); pix_gray = {sum, 2'b00}. 0xF on all channels -> 240.
- FSM states:
  - UNLOCKED -> SEARCH on the first vsync fall.
  - SEARCH: every hsync period must equal H_TOTAL. At the next vsync fall, if all periods matched and the line count equals V_TOTAL -> LOCKED; otherwise stay in SEARCH and restart measurement.
  - LOCKED: any hsync period != H_TOTAL, or any vsync period != V_TOTAL lines -> sync_err pulse, go to SEARCH, pix_valid drops the next cycle.
  - Any state: no hsync fall for 2*H_TOTAL clocks -> UNLOCKED (no sync_err pulse if the FSM was not LOCKED).
- locked = (state == LOCKED).
- frame_start pulses only when locked, with pix_valid for (0,0).
- Simultaneous hsync fall and vsync fall in the same cycle: treated as hsync first, then v_arm is set, so v_cnt = 0 lands on the following line.
- Glitch filtering is out of scope: a sync pulse shorter than 1 clock is not filtered.
- Reset mid-frame: immediate return to UNLOCKED; a full frame is needed to re-lock.

Optional Feature:
- Macro: VGA_RX_MEASURE_EN.
- Defined: adds output ports meas_h_total[15:0] and meas_v_total[15:0].
  - meas_h_total is the last hsync period; meas_v_total is the last vsync period in lines.
  - Both update on every vsync fall, whether or not the FSM is locked; reset value 0.
- Undefined: these ports and their registers are absent. Lock behaviour is identical either way.

Decomposition:
- Shared package vga_timing_pkg:
  - timing localparams H_TOTAL, V_TOTAL, H_ACT_START, V_ACT_START.
  - FSM state encoding: UNLOCKED = 2'd0, SEARCH = 2'd1, LOCKED = 2'd2.
  - gray conversion function.
- Timing parameters are shared with the VGA transmitter.
- One sub-module is natural: vga_sync_edge_det (input register + falling-edge detect for hsync/vsync), instantiated once.

Test Plan:
- Loopback with the VGA transmitter at default timing -> locked = 1 after the second vsync fall; frame_start once per frame (every 420000 clks); exactly 307200 pix_valid cycles per frame.
- Source RGB = 0xF/0x0/0x0 at pixel (10,20) -> pix_valid with pix_x = 10, pix_y = 20, pix_gray = 60. All channels 0xF -> pix_gray = 240.
- While locked, stretch one line to 801 clks -> sync_err single pulse, locked = 0 on the next cycle, no pix_valid until a clean frame completes; relock after 1 good frame.
- Stop hsync for 1600 clks -> locked = 0, no sync_err. Restart hsync -> SEARCH at the next vsync fall.
- Assert rst_n low mid-line 200 -> all outputs 0 within the same cycle; re-lock after a full frame.
- VGA_RX_MEASURE_EN defined, line length 808 -> meas_h_total = 808, meas_v_total = 525 after the vsync fall; locked stays 0.
